// File: rtl/wca_cic_interp_ctrl.sv
// wca_cic_interp_ctrl
//
// Sequencer for a 3-stage CIC interpolator. Generates the IF-rate strobe
// (strobe_if) and the input-rate strobe (strobe_cic), drives the CIC enable
// and rate ports, and feeds samples from the upstream TX source into the CIC
// through a one-entry hold register. The CIC is flushed (enable held low) on
// start and whenever the requested rate changes. Input starvation at a
// strobe_cic is reported as an underrun, and the CIC sees a zero sample.
//
// Ports
//   clock, reset        system clock, asynchronous active-low reset
//   enable              run request; low returns to IDLE on the next clock
//   cfg_log2_rate       log2 interpolation rate, values above 8 clamp to 8
//   cfg_if_div          IF strobe period minus 1, in clocks
//   clear_status        clears underrun / underrun_count
//   in_valid/in_data    upstream sample, accepted when in_valid & in_ready
//   in_ready            hold register can take a sample this clock
//   cic_enable          CIC enable (low clears CIC state)
//   cic_log2_rate       latched, clamped rate presented to the CIC
//   cic_data_in         current hold register contents
//   strobe_cic          comb-section update strobe, 1 clock wide
//   strobe_if           integrator-section strobe, 1 clock wide
//   running             high while in RUN
//   underrun            sticky starvation flag
//   underrun_count      saturating starvation counter
module wca_cic_interp_ctrl #(
  parameter int WIDTH        = 16,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3:0]           cfg_log2_rate,
  input  logic [7:0]           cfg_if_div,
  input  logic                 clear_status,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 cic_enable,
  output logic [3:0]           cic_log2_rate,
  output logic [WIDTH-1:0]     cic_data_in,
  output logic                 strobe_cic,
  output logic                 strobe_if,
  output logic                 running,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] underrun_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0]       FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0]       FLUSH_ONE  = FCW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [3:0]           rate_q, rate_d;
  logic [7:0]           div_q, div_d;
  logic [7:0]           div_cnt_q, div_cnt_d;
  logic [7:0]           phase_q, phase_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 strobe_if_q, strobe_if_d;
  logic                 strobe_cic_q, strobe_cic_d;
  logic                 cic_enable_q, cic_enable_d;
  logic [3:0]           cic_rate_q, cic_rate_d;
  logic                 running_q, running_d;
  logic                 underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0] underrun_count_q, underrun_count_d;

  logic [3:0]           rate_clamped;
  logic [7:0]           phase_mask;

  // Requested rate limited to the CIC's supported range.
  assign rate_clamped = (cfg_log2_rate > 4'd8) ? 4'd8 : cfg_log2_rate;

  // Phase wraps modulo 2^rate_q; rate_q never exceeds 8.
  assign phase_mask = 8'hFF >> (4'd8 - rate_q);

  // The hold register is free when empty, or when it is being consumed by
  // the strobe_cic of this very clock.
  assign in_ready = running_q & (~hold_valid_q | strobe_cic_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    rate_d           = rate_q;
    div_d            = div_q;
    div_cnt_d        = div_cnt_q;
    phase_d          = phase_q;
    hold_d           = hold_q;
    hold_valid_d     = hold_valid_q;
    underrun_d       = underrun_q;
    underrun_count_d = underrun_count_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FLUSH;
          rate_d  = rate_clamped;
          div_d   = cfg_if_div;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_ONE;
        end
      end
      RUN: begin
        div_cnt_d = (div_cnt_q == div_q) ? 8'd0 : div_cnt_q + 8'd1;
        if (strobe_if_q) begin
          phase_d = (phase_q + 8'd1) & phase_mask;
        end
        if (strobe_cic_q) begin
          // Held sample is consumed; refill from upstream in the same clock.
          hold_valid_d = in_valid;
          hold_d       = in_valid ? in_data : '0;
          // A pending rate change is applied only after a completed strobe_cic.
          if (rate_clamped != rate_q) begin
            state_d = FLUSH;
            rate_d  = rate_clamped;
            div_d   = cfg_if_div;
          end
        end else if (in_valid && in_ready) begin
          hold_d       = in_data;
          hold_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
    end

    // Counters and the hold register only live in RUN; anything delivered
    // around a flush is dropped.
    if (state_d != RUN) begin
      div_cnt_d    = 8'd0;
      phase_d      = 8'd0;
      hold_d       = '0;
      hold_valid_d = 1'b0;
    end
    if (state_d != FLUSH) begin
      flush_cnt_d = '0;
    end

    // Strobes are registered: they are decided one clock ahead from the
    // counter values the next clock will hold.
    strobe_if_d  = (state_d == RUN) && (div_cnt_d == div_d);
    strobe_cic_d = strobe_if_d && (phase_d == 8'd0);
    cic_enable_d = (state_d == RUN);
    running_d    = (state_d == RUN);
    cic_rate_d   = (state_d == RUN) ? rate_d : 4'd0;

    // Starvation takes precedence over a simultaneous clear, so a fresh
    // underrun is never lost.
    if (strobe_cic_q && !hold_valid_q) begin
      underrun_d = 1'b1;
      if (clear_status) begin
        underrun_count_d = CNT_ONE;
      end else if (!(&underrun_count_q)) begin
        underrun_count_d = underrun_count_q + CNT_ONE;
      end
    end else if (clear_status) begin
      underrun_d       = 1'b0;
      underrun_count_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      rate_q           <= 4'd0;
      div_q            <= 8'd0;
      div_cnt_q        <= 8'd0;
      phase_q          <= 8'd0;
      hold_q           <= '0;
      hold_valid_q     <= 1'b0;
      strobe_if_q      <= 1'b0;
      strobe_cic_q     <= 1'b0;
      cic_enable_q     <= 1'b0;
      cic_rate_q       <= 4'd0;
      running_q        <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      rate_q           <= rate_d;
      div_q            <= div_d;
      div_cnt_q        <= div_cnt_d;
      phase_q          <= phase_d;
      hold_q           <= hold_d;
      hold_valid_q     <= hold_valid_d;
      strobe_if_q      <= strobe_if_d;
      strobe_cic_q     <= strobe_cic_d;
      cic_enable_q     <= cic_enable_d;
      cic_rate_q       <= cic_rate_d;
      running_q        <= running_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign cic_enable     = cic_enable_q;
  assign cic_log2_rate  = cic_rate_q;
  assign cic_data_in    = hold_q;
  assign strobe_cic     = strobe_cic_q;
  assign strobe_if      = strobe_if_q;
  assign running        = running_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_wca_cic_interp_ctrl.sv
// tb_wca_cic_interp_ctrl
//
// Self-checking bench for wca_cic_interp_ctrl. Every sample the DUT accepts
// (and every deliberate zero-stuff) is queued as the expected CIC input; a
// monitor compares the queue head against cic_data_in on each strobe_cic.
// Timing, flush, rate, status and reset behaviour are checked directly.
module tb_wca_cic_interp_ctrl;

  localparam int WIDTH     = 16;
  localparam int CNT_WIDTH = 16;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [3:0]           cfg_log2_rate;
  logic [7:0]           cfg_if_div;
  logic                 clear_status;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 cic_enable;
  logic [3:0]           cic_log2_rate;
  logic [WIDTH-1:0]     cic_data_in;
  logic                 strobe_cic;
  logic                 strobe_if;
  logic                 running;
  logic                 underrun;
  logic [CNT_WIDTH-1:0] underrun_count;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] expQ[$];
  bit               discardAccepted = 1'b0;
  bit               sawStrobeCic;
  bit               sawStrobeIf;
  bit               accepted;
  int               ticks;
  int               ifSeen;

  always #5 clock = ~clock;

  wca_cic_interp_ctrl #(
    .WIDTH(WIDTH),
    .FLUSH_CYCLES(4),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .cfg_log2_rate(cfg_log2_rate),
    .cfg_if_div(cfg_if_div),
    .clear_status(clear_status),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .cic_enable(cic_enable),
    .cic_log2_rate(cic_log2_rate),
    .cic_data_in(cic_data_in),
    .strobe_cic(strobe_cic),
    .strobe_if(strobe_if),
    .running(running),
    .underrun(underrun),
    .underrun_count(underrun_count)
  );

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rate, input logic [7:0] ifDiv, input logic valid, input logic en);
    cfg_log2_rate = rate;
    cfg_if_div    = ifDiv;
    in_valid      = valid;
    enable        = en;
  endtask

  // One clock: sample strobes and handshake mid-cycle, then advance the
  // upstream ramp just after the edge that consumed a sample.
  task automatic tick();
    @(negedge clock);
    sawStrobeCic = strobe_cic;
    sawStrobeIf  = strobe_if;
    accepted     = in_valid && in_ready;
    @(posedge clock);
    #1;
    if (accepted) begin
      if (!discardAccepted) expQ.push_back(in_data);
      in_data = in_data + 16'd1;
    end
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for the next strobe_cic (wantCic=1) or strobe_if.
  task automatic waitStrobe(input bit wantCic, input int limit, output int nTicks, output int nIf);
    bit done;
    done   = 1'b0;
    nTicks = 0;
    nIf    = 0;
    while (!done && nTicks < limit) begin
      tick();
      nTicks++;
      if (sawStrobeIf) nIf++;
      if (sawStrobeCic) checkOutput("strobe_if with strobe_cic", 32'(sawStrobeIf), 32'd1);
      done = wantCic ? sawStrobeCic : sawStrobeIf;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL strobe timeout: got none expected one within %0d clocks", limit);
    end
  endtask

  // Flush after a rate change, then verify the new rate and strobe spacing.
  task automatic rateChange(input logic [3:0] newRate, input logic [3:0] expRate, input int oldPeriod,
                            input int newPeriod, input int newIfCount);
    cfg_log2_rate   = newRate;
    discardAccepted = 1'b1;
    waitStrobe(1'b1, oldPeriod + 8, ticks, ifSeen);
    discardAccepted = 1'b0;
    checkOutput("last strobe before flush spacing", 32'(ticks), 32'(oldPeriod));
    checkOutput("flush first clock cic_enable", 32'(cic_enable), 32'd0);
    checkOutput("flush first clock in_ready", 32'(in_ready), 32'd0);
    tickN(3);
    checkOutput("flush last clock cic_enable", 32'(cic_enable), 32'd0);
    tick();
    checkOutput("after flush cic_enable", 32'(cic_enable), 32'd1);
    checkOutput("after flush cic_log2_rate", 32'(cic_log2_rate), 32'(expRate));
    waitStrobe(1'b1, 16, ticks, ifSeen);
    checkOutput("first strobe_cic RUN clock", 32'(ticks), 32'd4);
    waitStrobe(1'b1, newPeriod + 16, ticks, ifSeen);
    checkOutput("strobe_cic period", 32'(ticks), 32'(newPeriod));
    checkOutput("strobe_if per strobe_cic", 32'(ifSeen), 32'(newIfCount));
  endtask

  // Scoreboard monitor: each strobe_cic must present the oldest expected sample.
  always @(negedge clock) begin
    logic [WIDTH-1:0] expected;
    if (reset && strobe_cic) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard empty: got sample %0d expected none", cic_data_in);
      end else begin
        expected = expQ.pop_front();
        checkOutput("scoreboard cic_data_in", 32'(cic_data_in), 32'(expected));
      end
    end
  end

  // Runaway guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    reset        = 1'b0;
    clear_status = 1'b0;
    in_data      = '0;
    applyStimulus(4'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset running", 32'(running), 32'd0);
    checkOutput("reset cic_enable", 32'(cic_enable), 32'd0);
    checkOutput("reset strobe_if", 32'(strobe_if), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset underrun_count", 32'(underrun_count), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("idle running", 32'(running), 32'd0);

    // Start: rate 2, IF divider 3, ramp 1,2,3.. always offered.
    in_data = 16'd1;
    applyStimulus(4'd2, 8'd3, 1'b1, 1'b1);
    tickN(4);
    checkOutput("start flush cic_enable", 32'(cic_enable), 32'd0);
    checkOutput("start flush in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("run cic_enable", 32'(cic_enable), 32'd1);
    checkOutput("run running", 32'(running), 32'd1);
    checkOutput("run cic_log2_rate", 32'(cic_log2_rate), 32'd2);
    checkOutput("run first clock in_ready", 32'(in_ready), 32'd1);
    waitStrobe(1'b1, 16, ticks, ifSeen);
    checkOutput("first strobe_cic RUN clock", 32'(ticks), 32'd4);
    checkOutput("first strobe_if count", 32'(ifSeen), 32'd1);
    waitStrobe(1'b1, 32, ticks, ifSeen);
    checkOutput("strobe_cic period rate2", 32'(ticks), 32'd16);
    checkOutput("strobe_if per strobe_cic rate2", 32'(ifSeen), 32'd4);
    waitStrobe(1'b0, 16, ticks, ifSeen);
    checkOutput("strobe_if period", 32'(ticks), 32'd4);
    waitStrobe(1'b1, 32, ticks, ifSeen);
    checkOutput("strobe_cic remainder", 32'(ticks), 32'd12);
    checkOutput("streaming underrun", 32'(underrun), 32'd0);
    checkOutput("streaming underrun_count", 32'(underrun_count), 32'd0);

    // Starvation: held sample drains, then three zero-stuffed strobes.
    in_valid = 1'b0;
    repeat (3) expQ.push_back('0);
    waitStrobe(1'b1, 32, ticks, ifSeen);
    checkOutput("drain underrun", 32'(underrun), 32'd0);
    waitStrobe(1'b1, 32, ticks, ifSeen);
    checkOutput("first underrun flag", 32'(underrun), 32'd1);
    checkOutput("first underrun_count", 32'(underrun_count), 32'd1);
    waitStrobe(1'b1, 32, ticks, ifSeen);
    checkOutput("second underrun_count", 32'(underrun_count), 32'd2);
    tickN(15);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    checkOutput("clear on underrun clock aligned", 32'(sawStrobeCic), 32'd1);
    checkOutput("underrun wins over clear flag", 32'(underrun), 32'd1);
    checkOutput("underrun wins over clear count", 32'(underrun_count), 32'd1);
    in_valid     = 1'b1;
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    checkOutput("clear underrun", 32'(underrun), 32'd0);
    checkOutput("clear underrun_count", 32'(underrun_count), 32'd0);

    // Rate changes: 2 -> 5, 5 -> 12 (clamped to 8), 8 -> 0.
    waitStrobe(1'b1, 32, ticks, ifSeen);
    rateChange(4'd5, 4'd5, 16, 128, 32);
    rateChange(4'd12, 4'd8, 128, 1024, 256);
    rateChange(4'd0, 4'd0, 1024, 4, 1);

    // Underrun at rate 0, then disable: status must survive IDLE.
    in_valid = 1'b0;
    expQ.push_back('0);
    waitStrobe(1'b1, 16, ticks, ifSeen);
    checkOutput("rate0 drain underrun", 32'(underrun), 32'd0);
    waitStrobe(1'b1, 16, ticks, ifSeen);
    checkOutput("rate0 underrun_count", 32'(underrun_count), 32'd1);
    enable = 1'b0;
    tick();
    checkOutput("disable running", 32'(running), 32'd0);
    checkOutput("disable cic_enable", 32'(cic_enable), 32'd0);
    checkOutput("disable strobe_if", 32'(strobe_if), 32'd0);
    checkOutput("disable strobe_cic", 32'(strobe_cic), 32'd0);
    checkOutput("disable in_ready", 32'(in_ready), 32'd0);
    checkOutput("disable cic_log2_rate", 32'(cic_log2_rate), 32'd0);
    checkOutput("disable underrun held", 32'(underrun), 32'd1);
    checkOutput("disable underrun_count held", 32'(underrun_count), 32'd1);
    expQ.delete();

    // Restart and hit reset in the middle of a strobe clock.
    in_valid = 1'b1;
    enable   = 1'b1;
    tickN(5);
    checkOutput("restart running", 32'(running), 32'd1);
    waitStrobe(1'b1, 16, ticks, ifSeen);
    checkOutput("restart first strobe_cic", 32'(ticks), 32'd4);
    tickN(3);
    checkOutput("pre-reset strobe_cic", 32'(strobe_cic), 32'd1);
    checkOutput("pre-reset underrun held", 32'(underrun), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset strobe_cic", 32'(strobe_cic), 32'd0);
    checkOutput("async reset strobe_if", 32'(strobe_if), 32'd0);
    checkOutput("async reset cic_enable", 32'(cic_enable), 32'd0);
    checkOutput("async reset running", 32'(running), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("async reset cic_data_in", 32'(cic_data_in), 32'd0);
    checkOutput("async reset underrun", 32'(underrun), 32'd0);
    checkOutput("async reset underrun_count", 32'(underrun_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
